// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch front end.
package fetch_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [31:0] PC_INCR   = 32'd4;

   typedef enum logic {
      SEQ   = 1'b0,
      DSLOT = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/fetch_pc_pair.sv
// PC/nPC register pair with +4 increment and taken-branch redirect mux.
// A redirect is only accepted when both load enables are high; otherwise the
// enables act independently and the hazard unit re-presents the branch.
module fetch_pc_pair #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_pc_le,
   input  logic        i_npc_le,
   input  logic        i_branch_taken,
   input  logic [31:0] i_target_addr,
   output logic [31:0] o_pc,
   output logic [31:0] o_npc,
   output logic        o_redirect
);
   import fetch_pkg::*;

   logic [31:0] r_pc;
   logic [31:0] r_npc;
   logic [31:0] w_pc_nxt;
   logic [31:0] w_npc_nxt;
   logic        w_redirect;

   assign w_redirect = i_branch_taken & i_pc_le & i_npc_le;

   // Next PC/nPC: redirect overrides the sequential step; addition wraps mod 2^32.
   always_comb begin
      w_pc_nxt  = r_pc;
      w_npc_nxt = r_npc;
      if (w_redirect) begin
         w_pc_nxt  = i_target_addr;
         w_npc_nxt = i_target_addr + PC_INCR;
      end else begin
         if (i_pc_le)  w_pc_nxt  = r_npc;
         if (i_npc_le) w_npc_nxt = r_npc + PC_INCR;
      end
   end

   // PC/nPC state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc  <= RESET_PC;
         r_npc <= RESET_PC + PC_INCR;
      end else begin
         r_pc  <= w_pc_nxt;
         r_npc <= w_npc_nxt;
      end
   end

   assign o_pc       = r_pc;
   assign o_npc      = r_npc;
   assign o_redirect = w_redirect;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC/nPC pair, IF/ID register, delay-slot FSM
// and fetch counter. Define BRANCH_LIKELY_EN to squash the delay slot of an
// untaken branch-likely (annul) into a NOP; otherwise annul is ignored.
module fetch_unit #(
   parameter int          ADDR_W   = 9,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pc_le,
   input  logic              npc_le,
   input  logic              if_id_le,
   input  logic              branch_taken,
   input  logic [31:0]       target_addr,
   input  logic              annul,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_data,
   output logic [31:0]       pc_out,
   output logic [31:0]       npc_out,
   output logic [31:0]       instruction_reg,
   output logic [31:0]       if_id_pc,
   output logic              in_delay_slot,
   output logic [31:0]       fetch_count
);
   import fetch_pkg::*;

   logic [31:0]  w_pc;
   logic [31:0]  w_npc;
   logic         w_redirect;
   logic         w_squash;
   fetch_state_e r_state;
   fetch_state_e w_state_nxt;
   logic [31:0]  r_instr;
   logic [31:0]  r_if_id_pc;
   logic [31:0]  r_fetch_count;

   fetch_pc_pair #(
      .RESET_PC (RESET_PC)
   ) u_pc_pair (
      .clk            (clk),
      .rst            (reset),
      .i_pc_le        (pc_le),
      .i_npc_le       (npc_le),
      .i_branch_taken (branch_taken),
      .i_target_addr  (target_addr),
      .o_pc           (w_pc),
      .o_npc          (w_npc),
      .o_redirect     (w_redirect)
   );

`ifdef BRANCH_LIKELY_EN
   // Untaken branch-likely: the delay-slot word is replaced by a NOP.
   assign w_squash = annul & ~branch_taken;
`else
   logic w_unused_annul;
   assign w_unused_annul = annul;
   assign w_squash       = 1'b0;
`endif

   // Delay-slot tracking: only advances on cycles that load IF/ID. A squash
   // implies no redirect, so it naturally lands in SEQ.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         SEQ:     if (if_id_le && w_redirect)  w_state_nxt = DSLOT;
         DSLOT:   if (if_id_le && !w_redirect) w_state_nxt = SEQ;
         default: w_state_nxt = SEQ;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= SEQ;
      else       r_state <= w_state_nxt;
   end

   // IF/ID pipeline register: captures the word fetched at the current PC.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_instr    <= NOP_INSTR;
         r_if_id_pc <= 32'h0;
      end else if (if_id_le) begin
         r_instr    <= w_squash ? NOP_INSTR : imem_data;
         r_if_id_pc <= w_pc;
      end
   end

   // Count of IF/ID loads, annulled loads included; wraps naturally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)         r_fetch_count <= 32'h0;
      else if (if_id_le) r_fetch_count <= r_fetch_count + 32'd1;
   end

   assign imem_addr       = w_pc[ADDR_W-1:0];
   assign pc_out          = w_pc;
   assign npc_out         = w_npc;
   assign instruction_reg = r_instr;
   assign if_id_pc        = r_if_id_pc;
   assign in_delay_slot   = (r_state == DSLOT);
   assign fetch_count     = r_fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a directed vector table, an async-reset
// sequence during a delay slot, then randomized traffic against a reference model.
module tb_fetch_unit;

   localparam int AW = 9;

   logic          clk;
   logic          reset;
   logic          pc_le, npc_le, if_id_le, branch_taken, annul;
   logic [31:0]   target_addr;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_data;
   logic [31:0]   pc_out, npc_out, instruction_reg, if_id_pc, fetch_count;
   logic          in_delay_slot;
   logic [22:0]   tag;

   int checks;
   int failures;

   // instruction memory: word = {tag, byte address}
   assign imem_data = {tag, imem_addr};

   fetch_unit #(.ADDR_W(AW), .RESET_PC(32'h0000_0000)) dut (
      .clk             (clk),
      .reset           (reset),
      .pc_le           (pc_le),
      .npc_le          (npc_le),
      .if_id_le        (if_id_le),
      .branch_taken    (branch_taken),
      .target_addr     (target_addr),
      .annul           (annul),
      .imem_addr       (imem_addr),
      .imem_data       (imem_data),
      .pc_out          (pc_out),
      .npc_out         (npc_out),
      .instruction_reg (instruction_reg),
      .if_id_pc        (if_id_pc),
      .in_delay_slot   (in_delay_slot),
      .fetch_count     (fetch_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        ple, nle, ifle, bt, an;
      logic [31:0] tgt;
      logic [31:0] pc, npc, ir, ifpc;
      logic        ds;
      logic [31:0] cnt;
   } vec_t;

`ifdef BRANCH_LIKELY_EN
   localparam logic [31:0] ANN_IR = 32'h0;
`else
   localparam logic [31:0] ANN_IR = 32'h4c;
`endif

   vec_t tbl[23];

   // reference model state
   logic [31:0] m_pc, m_npc, m_ir, m_ifpc, m_cnt;
   logic        m_ds;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_npc = 32'h4; m_ir = 32'h0; m_ifpc = 32'h0; m_ds = 1'b0; m_cnt = 32'h0;
   endtask

   // one clock edge of architectural behaviour, from the pre-edge inputs
   task automatic model_edge();
      logic [31:0] word, old_pc, old_npc;
      logic        red, sq;
      word    = {tag, m_pc[AW-1:0]};
      old_pc  = m_pc;
      old_npc = m_npc;
      red     = branch_taken && pc_le && npc_le;
`ifdef BRANCH_LIKELY_EN
      sq = annul && !branch_taken;
`else
      sq = 1'b0;
`endif
      if (red) begin
         m_pc  = target_addr;
         m_npc = target_addr + 32'd4;
      end else begin
         if (pc_le)  m_pc  = old_npc;
         if (npc_le) m_npc = old_npc + 32'd4;
      end
      if (if_id_le) begin
         m_ir   = sq ? 32'h0 : word;
         m_ifpc = old_pc;
         m_ds   = red;
         m_cnt  = m_cnt + 32'd1;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic chk_all(input string p, input logic [31:0] e_pc, e_npc, e_ir, e_ifpc,
                          input logic e_ds, input logic [31:0] e_cnt);
      chk({p, "_pc"},   pc_out, e_pc);
      chk({p, "_npc"},  npc_out, e_npc);
      chk({p, "_ir"},   instruction_reg, e_ir);
      chk({p, "_ifpc"}, if_id_pc, e_ifpc);
      chk({p, "_ds"},   {31'b0, in_delay_slot}, {31'b0, e_ds});
      chk({p, "_cnt"},  fetch_count, e_cnt);
      chk({p, "_addr"}, {23'b0, imem_addr}, {23'b0, e_pc[AW-1:0]});
   endtask

   task automatic set_in(input logic ple, nle, ifle, bt, an, input logic [31:0] tgt);
      pc_le = ple; npc_le = nle; if_id_le = ifle; branch_taken = bt; annul = an; target_addr = tgt;
   endtask

   initial begin
      checks = 0; failures = 0;
      //            ple nle ifle bt an  tgt            pc            npc           ir        ifpc          ds  cnt
      tbl[0]  = '{1, 1, 1, 0, 0, 32'h0,        32'h4,        32'h8,        32'h0,    32'h0,        0, 1};
      tbl[1]  = '{1, 1, 1, 0, 0, 32'h0,        32'h8,        32'hc,        32'h4,    32'h4,        0, 2};
      tbl[2]  = '{1, 1, 1, 0, 0, 32'h0,        32'hc,        32'h10,       32'h8,    32'h8,        0, 3};
      tbl[3]  = '{1, 1, 1, 0, 0, 32'h0,        32'h10,       32'h14,       32'hc,    32'hc,        0, 4};
      tbl[4]  = '{1, 1, 1, 0, 0, 32'h0,        32'h14,       32'h18,       32'h10,   32'h10,       0, 5};
      tbl[5]  = '{1, 1, 1, 1, 0, 32'h40,       32'h40,       32'h44,       32'h14,   32'h14,       1, 6};
      tbl[6]  = '{1, 1, 1, 0, 0, 32'h0,        32'h44,       32'h48,       32'h40,   32'h40,       0, 7};
      tbl[7]  = '{1, 1, 1, 0, 0, 32'h0,        32'h48,       32'h4c,       32'h44,   32'h44,       0, 8};
      tbl[8]  = '{0, 0, 0, 1, 0, 32'h100,      32'h48,       32'h4c,       32'h44,   32'h44,       0, 8};
      tbl[9]  = '{0, 0, 0, 1, 0, 32'h100,      32'h48,       32'h4c,       32'h44,   32'h44,       0, 8};
      tbl[10] = '{0, 0, 0, 1, 0, 32'h100,      32'h48,       32'h4c,       32'h44,   32'h44,       0, 8};
      tbl[11] = '{1, 0, 1, 0, 0, 32'h0,        32'h4c,       32'h4c,       32'h48,   32'h48,       0, 9};
      tbl[12] = '{1, 1, 1, 0, 0, 32'h0,        32'h4c,       32'h50,       32'h4c,   32'h4c,       0, 10};
      tbl[13] = '{1, 1, 1, 0, 1, 32'h0,        32'h50,       32'h54,       ANN_IR,   32'h4c,       0, 11};
      tbl[14] = '{1, 0, 1, 1, 0, 32'h100,      32'h54,       32'h54,       32'h50,   32'h50,       0, 12};
      tbl[15] = '{1, 1, 1, 1, 0, 32'h80,       32'h80,       32'h84,       32'h54,   32'h54,       1, 13};
      tbl[16] = '{1, 1, 1, 1, 0, 32'hc0,       32'hc0,       32'hc4,       32'h80,   32'h80,       1, 14};
      tbl[17] = '{1, 1, 1, 0, 0, 32'h0,        32'hc4,       32'hc8,       32'hc0,   32'hc0,       0, 15};
      tbl[18] = '{1, 1, 0, 1, 0, 32'h1f0,      32'h1f0,      32'h1f4,      32'hc0,   32'hc0,       0, 15};
      tbl[19] = '{1, 1, 1, 0, 0, 32'h0,        32'h1f4,      32'h1f8,      32'h1f0,  32'h1f0,      0, 16};
      tbl[20] = '{1, 1, 1, 1, 0, 32'hffff_fff8, 32'hffff_fff8, 32'hffff_fffc, 32'h1f4, 32'h1f4,      1, 17};
      tbl[21] = '{1, 1, 1, 0, 0, 32'h0,        32'hffff_fffc, 32'h0,       32'h1f8,  32'hffff_fff8, 0, 18};
      tbl[22] = '{1, 1, 1, 0, 0, 32'h0,        32'h0,        32'h4,        32'h1fc,  32'hffff_fffc, 0, 19};

      tag = '0;
      reset = 1'b1;
      set_in(0, 0, 0, 0, 0, 32'h0);
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      chk_all("reset", 32'h0, 32'h4, 32'h0, 32'h0, 1'b0, 32'h0);
      reset = 1'b0;

      // directed vectors
      for (int i = 0; i < 23; i++) begin
         set_in(tbl[i].ple, tbl[i].nle, tbl[i].ifle, tbl[i].bt, tbl[i].an, tbl[i].tgt);
         step();
         chk_all($sformatf("row%0d", i), tbl[i].pc, tbl[i].npc, tbl[i].ir, tbl[i].ifpc,
                 tbl[i].ds, tbl[i].cnt);
      end

      // enter a delay slot, then assert reset asynchronously mid-cycle
      set_in(1, 1, 1, 1, 0, 32'h60);
      step();
      chk("dslot_enter_ds", {31'b0, in_delay_slot}, 32'h1);
      chk("dslot_enter_pc", pc_out, 32'h60);
      set_in(1, 1, 1, 0, 0, 32'h0);
      #2;
      reset = 1'b1;
      #1;
      chk_all("async_rst", 32'h0, 32'h4, 32'h0, 32'h0, 1'b0, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
      step();
      chk_all("first_fetch", 32'h4, 32'h8, 32'h0, 32'h0, 1'b0, 32'h1);

      // randomized traffic against the reference model
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] t;
         t = $urandom;
         if ($urandom_range(0, 9) == 0) t = 32'hffff_fff0 | (t & 32'hc);
         set_in($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8,
                $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, {t[31:2], 2'b00});
         tag = 23'($urandom);
         step();
         chk_all($sformatf("rnd%0d", n), m_pc, m_npc, m_ir, m_ifpc, m_ds, m_cnt);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end of the 5-stage MIPS pipeline, directly upstream of the ID stage. Holds the PC/nPC register pair and the +4 increment, drives the instruction-memory address, and captures the fetched word into the IF/ID pipeline register. Honours the hazard unit's load enables and the condition handler's taken-branch redirect, with one architectural delay slot.

## Interface
- ADDR_W, 9, instruction-memory address width (word array indexed by byte address).
- RESET_PC, 32'h0000_0000, PC value after reset.

- clk  in  1  pipeline clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- pc_le  in  1  PC load enable from hazard unit (0 = hold).
- npc_le  in  1  nPC load enable from hazard unit (0 = hold).
- if_id_le  in  1  IF/ID register load enable from hazard unit (0 = hold).
- branch_taken  in  1  condition-handler result for the branch currently in ID.
- target_addr  in  32  branch/jump target address from ID.
- annul  in  1  branch-likely flag of the branch in ID (see Configuration).
- imem_addr  out  ADDR_W  = pc_out[ADDR_W-1:0], combinational.
- imem_data  in  32  instruction word returned by instruction memory (combinational read).
- pc_out  out  32  current PC.
- npc_out  out  32  current nPC.
- instruction_reg  out  32  IF/ID instruction.
- if_id_pc  out  32  PC of the instruction in instruction_reg (used for PC+8 link).
- in_delay_slot  out  1  instruction_reg holds a delay-slot instruction.
- fetch_count  out  32  count of IF/ID loads since reset.

## Operation
- Redirect accepted when branch_taken & pc_le & npc_le; branch_taken with either LE low is ignored (hazard unit re-presents the branch).
- Accepted redirect: pc <= target_addr, npc <= target_addr + 4.
- Otherwise: if pc_le, pc <= npc; if npc_le, npc <= npc + 4. Addition modulo 2^32, wraps FFFF_FFFC -> 0000_0000.
- IF/ID: if if_id_le, instruction_reg <= imem_data, if_id_pc <= pc_out; else both hold.
- Delay slot: the instruction fetched in the cycle the redirect is accepted (PC = branch+4) is always loaded into IF/ID; target fetched the following cycle.
- FSM, 2 states: SEQ (reset) and DSLOT. SEQ -> DSLOT on accepted redirect with if_id_le high. DSLOT -> SEQ on next if_id_le cycle without accepted redirect; DSLOT stays DSLOT on another accepted redirect (branch in delay slot: last redirect wins). if_id_le low holds state. in_delay_slot = (state == DSLOT).
- fetch_count increments by 1 on every cycle with if_id_le high (including annulled loads); wraps FFFF_FFFF -> 0.
- Reset values: pc_out = RESET_PC, npc_out = RESET_PC + 4, instruction_reg = 0 (NOP), if_id_pc = 0, in_delay_slot = 0, fetch_count = 0, state SEQ. Reset asserted mid-stall or mid-redirect discards everything.

## Timing
- imem_addr follows pc_out with zero latency; instruction_reg valid one cycle after PC presents an address.
- Redirect latency: branch_taken sampled at edge N; imem_addr = target_addr after edge N; target word in instruction_reg after edge N+1.
- LEs are independent; pc_le=1, npc_le=0 is legal (pc <= npc, npc holds).
- First fetch from RESET_PC on the first rising edge after reset deasserts.

## Configuration
- BRANCH_LIKELY_EN defined: when if_id_le & annul & ~branch_taken, instruction_reg loads 32'h0 (NOP) instead of imem_data, if_id_pc loads normally, state -> SEQ; delay slot of untaken branch-likely is squashed.
- Undefined: annul port present but ignored; delay slot always executes.

## Structure
- Package fetch_pkg: NOP_INSTR (32'h0), PC_INCR (4), fetch state enum {SEQ, DSLOT}.
- One sub-module, fetch_pc_pair: PC/nPC registers, +4 adder, redirect mux, LEs; top keeps IF/ID register, FSM, counter, annul.

## Test plan
- Reset, release, all LEs 1, imem returns address-tagged words -> pc_out 0,4,8,...; instruction_reg tracks one cycle behind; fetch_count = cycles since release.
- Branch at 0x10 taken to 0x40 -> instruction_reg sequence 0x10, 0x14 (in_delay_slot=1), 0x40, 0x44; pc_out 0x14 then 0x40.
- pc_le=npc_le=if_id_le=0 for 3 cycles with branch_taken=1 at PC 0x20 -> all state frozen, redirect ignored, fetch_count unchanged.
- BRANCH_LIKELY_EN, annul=1, branch_taken=0 at ID branch 0x30 -> instruction_reg = 0 with if_id_pc = 0x34; without macro -> instruction_reg = word at 0x34.
- npc = FFFF_FFFC, sequential step -> npc_out = 0000_0000; fetch_count preloaded via FFFF_FFFF loads -> wraps to 0.
- reset asserted asynchronously mid-cycle during DSLOT -> outputs immediately pc_out=RESET_PC, npc_out=RESET_PC+4, instruction_reg=0, in_delay_slot=0.
